// File: rtl/vsegscan_pkg.sv
// Shared display constants for the seven-segment display blocks.
//
// Contents:
//   SEG_0 .. SEG_F  active-low {g,f,e,d,c,b,a} codes for hex digits 0..F
//   SEG_BLANK       all segments off
//   AN_OFF          all digit enables off (active-low)
//   digit_idx_t     2-bit index of the currently scanned digit
//   an_onehot_l()   digit index -> active-low one-hot digit enable
package vsegscan_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    function automatic logic [3:0] an_onehot_l(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/vsevenseg.sv
// Hex nibble to active-low seven-segment decoder (purely combinational).
//
// Ports:
//   nibble  in   4  hex digit to display
//   seg_L   out  7  active-low segments {g,f,e,d,c,b,a}
module vsevenseg
    import vsegscan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_L
);

    always_comb begin
        seg_L = SEG_BLANK;
        case (nibble)
            4'h0: seg_L = SEG_0;
            4'h1: seg_L = SEG_1;
            4'h2: seg_L = SEG_2;
            4'h3: seg_L = SEG_3;
            4'h4: seg_L = SEG_4;
            4'h5: seg_L = SEG_5;
            4'h6: seg_L = SEG_6;
            4'h7: seg_L = SEG_7;
            4'h8: seg_L = SEG_8;
            4'h9: seg_L = SEG_9;
            4'hA: seg_L = SEG_A;
            4'hB: seg_L = SEG_B;
            4'hC: seg_L = SEG_C;
            4'hD: seg_L = SEG_D;
            4'hE: seg_L = SEG_E;
            4'hF: seg_L = SEG_F;
            default: seg_L = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/vsegscan.sv
// Four-digit multiplexed hex display driver.
//
// Holds a 16-bit value plus an overflow flag and scans its four nibbles onto
// a common seven-segment display, one digit every REFRESH_DIV clocks.
//
// Ports:
//   clk       in   1   single clock, rising edge
//   rst       in   1   synchronous active-high reset
//   load      in   1   single-cycle strobe capturing value and oflow_in
//   value     in   16  four hex nibbles, digit 0 = value[3:0]
//   oflow_in  in   1   overflow flag, shown as digit 0 decimal point
//   blank_en  in   1   leading-zero blanking enable (live)
//   seg_L     out  7   active-low segments {g,f,e,d,c,b,a}
//   an_L      out  4   active-low digit enables
//   dp_L      out  1   active-low decimal point
module vsegscan
    import vsegscan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        oflow_in,
    input  logic        blank_en,
    output logic [6:0]  seg_L,
    output logic [3:0]  an_L,
    output logic        dp_L
);

    localparam logic [15:0] CNT_MAX = 16'(REFRESH_DIV - 1);

    logic [15:0] val_q, val_d;
    logic        ofl_q, ofl_d;
    logic [15:0] cnt_q, cnt_d;
    digit_idx_t  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q,  an_d;
    logic        dp_q,  dp_d;

    logic        wrap;
    logic [3:0]  nibble;
    logic [6:0]  dec_seg;
    logic        blank;

    vsevenseg u_dec (
        .nibble (nibble),
        .seg_L  (dec_seg)
    );

    always_comb begin
        val_d = val_q;
        ofl_d = ofl_q;
        if (load) begin
            val_d = value;
            ofl_d = oflow_in;
        end

        // Load never touches the scan timing; a load on the wrap cycle simply
        // lands together with the digit advance.
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        nibble = 4'h0;
        blank  = 1'b0;
        case (idx_q)
            2'd0: nibble = val_q[3:0];
            2'd1: begin
                nibble = val_q[7:4];
                blank  = (val_q[15:4] == 12'd0);
            end
            2'd2: begin
                nibble = val_q[11:8];
                blank  = (val_q[15:8] == 8'd0);
            end
            2'd3: begin
                nibble = val_q[15:12];
                blank  = (val_q[15:12] == 4'd0);
            end
            default: begin
                nibble = 4'h0;
                blank  = 1'b0;
            end
        endcase

        // Blanking overrides the decoder; digit 0 never blanks so a zero
        // value still shows a single '0'.
        seg_d = (blank_en && blank) ? SEG_BLANK : dec_seg;
        an_d  = an_onehot_l(idx_q);
        dp_d  = !((idx_q == 2'd0) && ofl_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= 16'd0;
            ofl_q <= 1'b0;
            cnt_q <= 16'd0;
            idx_q <= 2'd0;
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
            dp_q  <= 1'b1;
        end else begin
            val_q <= val_d;
            ofl_q <= ofl_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg_L = seg_q;
    assign an_L  = an_q;
    assign dp_L  = dp_q;

endmodule

// File: tb/tb_vsegscan.sv
// Scoreboard bench for vsegscan with REFRESH_DIV=4.
// The stimulus process pushes the expected display for every cycle; the
// monitor pops one entry per falling edge and compares.
module tb_vsegscan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        oflow_in;
  logic        blank_en;
  logic [6:0]  seg_L;
  logic [3:0]  an_L;
  logic        dp_L;

  vsegscan #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .oflow_in (oflow_in),
    .blank_en (blank_en),
    .seg_L    (seg_L),
    .an_L     (an_L),
    .dp_L     (dp_L)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       chk;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   c;
  int   switch_at;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;

  logic [3:0] an_tab [4];
  logic [6:0] tab_now [4];
  logic [6:0] tab_next [4];
  logic       dp_now, dp_next;

  task automatic push(input logic chk, input logic [6:0] s, input logic [3:0] a, input logic d);
    sb.push_back(exp_t'{chk, s, a, d});
  endtask

  // Expected display for the current cycle c (cycles counted from the first
  // cycle after reset release), then advance one clock.
  task automatic step();
    int d;
    if (c >= switch_at) begin
      tab_now = tab_next;
      dp_now  = dp_next;
    end
    if (c == 0) begin
      push(1'b1, SB, 4'b1111, 1'b1);
    end else begin
      d = ((c - 1) / 4) % 4;
      push(1'b1, tab_now[d], an_tab[d], !(d == 0 && dp_now));
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input logic with_load);
    rst = 1'b1;
    if (with_load) begin
      load     = 1'b1;
      value    = 16'hFFFF;
      oflow_in = 1'b1;
    end
    push(1'b0, SB, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    load = 1'b0;
    push(1'b1, SB, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    c         = 0;
    tab_now   = '{S0, S0, S0, S0};
    tab_next  = '{S0, S0, S0, S0};
    dp_now    = 1'b0;
    dp_next   = 1'b0;
    switch_at = 0;
  endtask

  // Load in cycle N; blank_en is changed in cycle N+1 so both take effect
  // on the display in cycle N+2 together with the new value.
  task automatic do_load(input logic [15:0] v, input logic of, input logic be,
                         input logic [6:0] t0, input logic [6:0] t1,
                         input logic [6:0] t2, input logic [6:0] t3,
                         input logic dpe);
    load      = 1'b1;
    value     = v;
    oflow_in  = of;
    tab_next  = '{t0, t1, t2, t3};
    dp_next   = dpe;
    switch_at = c + 2;
    step();
    load     = 1'b0;
    blank_en = be;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        total++;
        if (seg_L !== e.seg) begin
          bad++;
          $display("FAIL seg t=%0t seg_L=%b expected %b", $time, seg_L, e.seg);
        end
        if (an_L !== e.an) begin
          bad++;
          $display("FAIL an t=%0t an_L=%b expected %b", $time, an_L, e.an);
        end
        if (dp_L !== e.dp) begin
          bad++;
          $display("FAIL dp t=%0t dp_L=%b expected %b", $time, dp_L, e.dp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    an_tab   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    oflow_in = 1'b0;
    blank_en = 1'b0;
    c        = 0;
    switch_at = 0;
    tab_now  = '{S0, S0, S0, S0};
    tab_next = '{S0, S0, S0, S0};
    dp_now   = 1'b0;
    dp_next  = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then idle scan of a zero value.
    do_reset(1'b0);
    run(20);

    // Full hex value, no blanking.
    do_load(16'h1A8F, 1'b0, 1'b0, SF, S8, SA, S1, 1'b0);
    run(18);

    // Leading-zero blanking.
    do_load(16'h0005, 1'b0, 1'b1, S5, SB, SB, SB, 1'b0);
    run(16);
    do_load(16'h0000, 1'b0, 1'b1, S0, SB, SB, SB, 1'b0);
    run(16);

    // Overflow decimal point on digit 0 only, then cleared.
    do_load(16'h0003, 1'b1, 1'b0, S3, S0, S0, S0, 1'b1);
    run(16);
    do_load(16'h0003, 1'b0, 1'b0, S3, S0, S0, S0, 1'b0);
    run(8);

    // Load on the dwell-wrap cycle.
    while ((c % 4) != 3) step();
    do_load(16'h1A8F, 1'b0, 1'b0, SF, S8, SA, S1, 1'b0);
    run(16);

    // Mid-scan reset with a simultaneous load: load is ignored.
    run(2);
    do_reset(1'b1);
    run(20);

    @(negedge clk);
    #1;
    if (bad != 0 || total == 0)
      $display("FAIL test done: total=%0d bad=%0d", total, bad);
    else
      $display("PASS test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vsegscan.md
VSEGSCAN -- requirements
Module: vsegscan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, SHALL set the clk cycles each digit stays active (legal range 2..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 load  input  1  SHALL be a single-cycle strobe that captures value and oflow_in.
REQ-005 value  input  16  SHALL be four hex nibbles; digit 0 = value[3:0], digit 3 = value[15:12].
REQ-006 oflow_in  input  1  SHALL be the adder overflow flag, captured with value.
REQ-007 blank_en  input  1  SHALL enable leading-zero blanking, sampled live each cycle.
REQ-008 seg_L  output  7  SHALL be the active-low segments {g,f,e,d,c,b,a} of the active digit.
REQ-009 an_L  output  4  SHALL be the active-low digit enables; an_L[i] low selects digit i.
REQ-010 dp_L  output  1  SHALL be the active-low decimal point of the active digit.

Function
REQ-011 A held register SHALL load value and oflow_in on any cycle where load=1 and rst=0, and SHALL otherwise keep its contents.
REQ-012 Dwell counter: counts 0..REFRESH_DIV-1, then wraps to 0.
REQ-013 Digit index (2 bits): advances 0->1->2->3->0 on the cycle the dwell counter wraps; otherwise holds.
REQ-014 load SHALL NOT reset or disturb the dwell counter or the digit index.
REQ-015 seg_L, an_L and dp_L SHALL be registered, with 1-cycle latency from the digit index and held-register state.
REQ-016 an_L SHALL be one-hot low: index 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-017 Segment encoding SHALL be the team hex table: 0 -> 1000000, 1 -> 1111001, 8 -> 0000000, A -> 0001000, F -> 0001110, blank -> 1111111.
REQ-018 With blank_en=1, digit i (i=3..1) SHALL show blank when nibble i and all higher nibbles are zero; digit 0 is never blanked.
REQ-019 dp_L SHALL be 0 only while digit 0 is active and held oflow=1; otherwise 1.
REQ-020 A load in cycle N SHALL appear on seg_L in cycle N+2 if the digit index is unchanged.
REQ-021 Simultaneous load and dwell wrap: both SHALL take effect in the same cycle.

Reset
REQ-022 rst=1 SHALL take priority over load.
REQ-023 rst=1 SHALL clear the held value to 0, held oflow to 0, dwell counter to 0 and digit index to 0.
REQ-024 rst=1 SHALL drive output registers to all-off: seg_L=1111111, an_L=1111, dp_L=1.
REQ-025 In the first cycle after rst deasserts, outputs SHALL remain all-off; from the second cycle, an_L=1110 and seg_L=1000000.
REQ-026 A reset asserted mid-scan SHALL take effect on the next clock edge with no partial-digit completion.

Structure
REQ-027 The segment code constants (hex 0..F, SEG_BLANK=1111111) and AN_OFF=1111 SHALL live in a shared include used by every display block.
REQ-028 Nibble-to-segment decode SHALL be one sub-module instance of vsevenseg, driven by the selected nibble.
REQ-029 Blanking and dp logic SHALL override the vsevenseg output before the output register.
REQ-030 No latches, one clock domain, no combinational path from inputs to outputs.

Verification (REFRESH_DIV=4)
REQ-031 Reset then idle 20 cycles -> an_L sequence 1110, 1101, 1011, 0111, each held for exactly 4 cycles; seg_L=1000000 throughout; dp_L=1.
REQ-032 load value=0x1A8F, blank_en=0 -> digits 0..3 show 0001110, 0000000, 0001000, 1111001.
REQ-033 load value=0x0005, blank_en=1 -> digit 0 shows 0010010; digits 1..3 show 1111111. Then value=0x0000 -> digit 0 shows 1000000; others blank.
REQ-034 load value=0x0003 with oflow_in=1 -> dp_L=0 only while an_L=1110. A following load with oflow_in=0 -> dp_L=1 within 2 cycles.
REQ-035 Assert load together with rst -> held value stays 0; outputs all-off that cycle.
REQ-036 Assert load on the dwell-wrap cycle -> new digit and new value appear together 2 cycles later, with no skipped digit.
